// File: rtl/cnt163_pkg.sv
// Shared types and constants for the cascaded 163-style counter sequencer.
// Slice mode encodings are the {e,f} control pair that each 4-bit slice decodes.
package cnt163_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_LOAD = 1'b0,
    GNT_RUN  = 1'b1
  } grant_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  localparam int SLICE_W = 4;

  function automatic logic slice_all_ones(input logic [SLICE_W-1:0] v);
    return &v;
  endfunction

endpackage

// File: rtl/cnt163_seq_ctrl_if.sv
// Request/status bundle between system control and the counter sequencer.
// master = the requesting control logic, slave = the sequencer.
interface cnt163_seq_ctrl_if #(
  parameter int SLICES = 2
);
  localparam int W = 4 * SLICES;

  logic                  ld_valid;
  logic [W-1:0]          ld_data;
  logic                  ld_ready;
  logic                  run_valid;
  logic [W-1:0]          run_len;
  logic                  run_ready;
  logic                  pause;
  logic                  abort;
  logic [W-1:0]          cnt_q;
  logic                  tc;
  logic [2*SLICES-1:0]   slice_mode;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    output ld_valid, ld_data, run_valid, run_len, pause, abort,
    input  ld_ready, run_ready, cnt_q, tc, slice_mode, busy, done, aborted
  );

  modport slave (
    input  ld_valid, ld_data, run_valid, run_len, pause, abort,
    output ld_ready, run_ready, cnt_q, tc, slice_mode, busy, done, aborted
  );

endinterface

// File: rtl/cnt163_rr_arb.sv
// Two-requester round-robin arbiter (load port vs run port).
// Grants only while enabled; on contention the port not granted last wins.
module cnt163_rr_arb
  import cnt163_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_ld_req,
  input  logic i_run_req,
  output logic o_ld_gnt,
  output logic o_run_gnt
);

  grant_t r_last_gnt;

  always_comb begin
    o_ld_gnt  = 1'b0;
    o_run_gnt = 1'b0;
    if (i_en) begin
      if (i_ld_req && i_run_req) begin
        if (r_last_gnt == GNT_LOAD) o_run_gnt = 1'b1;
        else                        o_ld_gnt  = 1'b1;
      end else if (i_ld_req) begin
        o_ld_gnt = 1'b1;
      end else if (i_run_req) begin
        o_run_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= GNT_LOAD;
    end else if (o_ld_gnt) begin
      r_last_gnt <= GNT_LOAD;
    end else if (o_run_gnt) begin
      r_last_gnt <= GNT_RUN;
    end
  end

endmodule

// File: rtl/cnt163_seq_ctrl.sv
// Sequencer/arbiter for a cascaded 163-style counter: owns the W-bit count
// register, drives per-slice modes and carry enables, and runs bounded count runs.
module cnt163_seq_ctrl
  import cnt163_pkg::*;
#(
  parameter int SLICES = 2
) (
  input  logic               clk,
  input  logic               rst,
  cnt163_seq_ctrl_if.slave   bus
);

  localparam int W = 4 * SLICES;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_cnt;
  logic [W-1:0]    w_cnt_nxt;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    w_rem_nxt;
  logic            r_abort;
  logic            w_abort_nxt;
  logic [1:0]      w_mode;

  logic            w_idle;
  logic            w_ld_gnt;
  logic            w_run_gnt;
  logic            w_inc;
  logic            w_carry_out;
  logic [SLICES-1:0] w_slice_en;
  logic [W-1:0]    w_cnt_inc;

  assign w_idle = (r_state == ST_IDLE);
  assign w_inc  = (r_state == ST_RUN) && !bus.abort && !bus.pause;

  cnt163_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_idle),
    .i_ld_req  (bus.ld_valid),
    .i_run_req (bus.run_valid),
    .o_ld_gnt  (w_ld_gnt),
    .o_run_gnt (w_run_gnt)
  );

  // Ripple carry across slices: slice k is enabled only when all lower slices are all-ones.
  always_comb begin
    logic carry;
    carry      = w_inc;
    w_slice_en = '0;
    w_cnt_inc  = r_cnt;
    for (int k = 0; k < SLICES; k++) begin
      w_slice_en[k] = carry;
      if (w_slice_en[k]) begin
        w_cnt_inc[4*k +: 4] = r_cnt[4*k +: 4] + 4'd1;
      end
      carry = carry & slice_all_ones(r_cnt[4*k +: 4]);
    end
    w_carry_out = carry;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_abort_nxt = r_abort;
    w_mode      = MODE_HOLD;
    case (r_state)
      ST_IDLE: begin
        if (w_ld_gnt) begin
          w_cnt_nxt   = bus.ld_data;
          w_state_nxt = ST_LOAD;
        end else if (w_run_gnt) begin
          w_rem_nxt   = bus.run_len;
          w_abort_nxt = 1'b0;
          w_state_nxt = (bus.run_len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_LOAD: begin
        w_mode      = MODE_LOAD;
        w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_FIN;
        end else if (!bus.pause) begin
          w_mode    = MODE_COUNT;
          w_cnt_nxt = w_cnt_inc;
          w_rem_nxt = r_rem - ONE;
          if (r_rem == ONE) w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign bus.ld_ready   = w_ld_gnt;
  assign bus.run_ready  = w_run_gnt;
  assign bus.cnt_q      = r_cnt;
  assign bus.tc         = w_carry_out;
  assign bus.slice_mode = {SLICES{w_mode}};
  assign bus.busy       = !w_idle;
  assign bus.done       = (r_state == ST_FIN) && !r_abort;
  assign bus.aborted    = (r_state == ST_FIN) && r_abort;

endmodule

// File: tb/tb_cnt163_seq_ctrl.sv
// Self-checking bench for cnt163_seq_ctrl: vector table of runs with a
// count scoreboard, plus hand sequences for arbitration, load timing and reset.
module tb_cnt163_seq_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  cnt163_seq_ctrl_if #(.SLICES(2)) u_if ();

  cnt163_seq_ctrl #(.SLICES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] start;
    logic [7:0] len;
    int         pause_at;
    int         pause_len;
    int         abort_at;
    logic [7:0] exp_final;
    logic       exp_done;
    logic       exp_ab;
    int         exp_cycles;
    int         exp_tcs;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] d);
    u_if.ld_valid = 1'b1;
    u_if.ld_data  = d;
    #1;
    chk("load_ready", {31'd0, u_if.ld_ready}, 32'd1);
    step();
    u_if.ld_valid = 1'b0;
    chk("load_value", {24'd0, u_if.cnt_q}, {24'd0, d});
    step();
  endtask

  task automatic run_vec(input int idx);
    vec_t       v;
    logic [7:0] exp_cnt;
    int         tcs;
    int         fin_cyc;
    logic       saw_done;
    logic       saw_ab;
    logic       pz;
    logic       ab;
    v = vecs[idx];
    do_load(v.start);
    u_if.run_valid = 1'b1;
    u_if.run_len   = v.len;
    #1;
    chk("run_ready", {31'd0, u_if.run_ready}, 32'd1);
    chk("run_ld_ready", {31'd0, u_if.ld_ready}, 32'd0);
    step();
    u_if.run_valid = 1'b0;
    exp_cnt  = v.start;
    tcs      = 0;
    fin_cyc  = -1;
    saw_done = 1'b0;
    saw_ab   = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (u_if.done || u_if.aborted) begin
        fin_cyc  = c;
        saw_done = u_if.done;
        saw_ab   = u_if.aborted;
        chk("fin_mode", {28'd0, u_if.slice_mode}, 32'd0);
        break;
      end
      pz = (c > v.pause_at) && (c <= v.pause_at + v.pause_len);
      ab = (c == v.abort_at);
      u_if.pause = pz;
      u_if.abort = ab;
      #1;
      if (!ab) chk("run_mode", {28'd0, u_if.slice_mode}, pz ? 32'h0 : 32'hF);
      chk("tc", {31'd0, u_if.tc}, {31'd0, (exp_cnt == 8'hFF) && !pz && !ab});
      if (u_if.tc) tcs++;
      if (!pz && !ab) exp_cnt = exp_cnt + 8'd1;
      sb.push_back(exp_cnt);
      step();
      u_if.pause = 1'b0;
      u_if.abort = 1'b0;
      chk("cnt_seq", {24'd0, u_if.cnt_q}, {24'd0, sb.pop_front()});
    end
    chk("fin_cycle", fin_cyc, v.exp_cycles);
    chk("done_seen", {31'd0, saw_done}, {31'd0, v.exp_done});
    chk("abort_seen", {31'd0, saw_ab}, {31'd0, v.exp_ab});
    chk("final_cnt", {24'd0, u_if.cnt_q}, {24'd0, v.exp_final});
    chk("tc_count", tcs, v.exp_tcs);
    step();
    chk("idle_busy", {31'd0, u_if.busy}, 32'd0);
    chk("pulse_width", {31'd0, u_if.done | u_if.aborted}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    clk = 1'b0;
    rst = 1'b1;
    u_if.ld_valid  = 1'b0;
    u_if.ld_data   = '0;
    u_if.run_valid = 1'b0;
    u_if.run_len   = '0;
    u_if.pause     = 1'b0;
    u_if.abort     = 1'b0;

    //                start  len  p_at p_len ab_at final done ab cyc tcs
    vecs[0] = '{8'hFD, 8'd5,  0, 0, 0, 8'h02, 1'b1, 1'b0, 6,  1};
    vecs[1] = '{8'h10, 8'd10, 4, 3, 0, 8'h1A, 1'b1, 1'b0, 14, 0};
    vecs[2] = '{8'h33, 8'd0,  0, 0, 0, 8'h33, 1'b1, 1'b0, 1,  0};
    vecs[3] = '{8'h40, 8'd8,  0, 0, 3, 8'h42, 1'b0, 1'b1, 4,  0};
    vecs[4] = '{8'h70, 8'd5,  1, 2, 3, 8'h71, 1'b0, 1'b1, 4,  0};
    vecs[5] = '{8'hFF, 8'd2,  0, 0, 0, 8'h01, 1'b1, 1'b0, 3,  1};
    vecs[6] = '{8'hFF, 8'd1,  0, 2, 0, 8'h00, 1'b1, 1'b0, 4,  1};

    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_cnt", {24'd0, u_if.cnt_q}, 32'd0);
    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst_mode", {28'd0, u_if.slice_mode}, 32'd0);
    chk("rst_done", {31'd0, u_if.done | u_if.aborted}, 32'd0);
    chk("rst_ready", {30'd0, u_if.ld_ready, u_if.run_ready}, 32'd0);
    chk("rst_tc", {31'd0, u_if.tc}, 32'd0);

    // Both requests held from reset: run first, then load, then run again.
    rst = 1'b1;
    u_if.ld_valid  = 1'b1;
    u_if.ld_data   = 8'hA5;
    u_if.run_valid = 1'b1;
    u_if.run_len   = 8'd1;
    step();
    rst = 1'b0;
    #1;
    chk("rr1_run", {30'd0, u_if.ld_ready, u_if.run_ready}, 32'd1);
    step();
    #1;
    chk("rr_busy_ready", {30'd0, u_if.ld_ready, u_if.run_ready}, 32'd0);
    step();
    chk("rr_done", {31'd0, u_if.done}, 32'd1);
    step();
    #1;
    chk("rr2_load", {30'd0, u_if.ld_ready, u_if.run_ready}, 32'd2);
    step();
    chk("rr_load_val", {24'd0, u_if.cnt_q}, 32'hA5);
    step();
    #1;
    chk("rr3_run", {30'd0, u_if.ld_ready, u_if.run_ready}, 32'd1);
    u_if.ld_valid  = 1'b0;
    u_if.run_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Load 5A with valid held: LOAD mode for one cycle, re-accept two cycles later.
    u_if.ld_valid = 1'b1;
    u_if.ld_data  = 8'h5A;
    #1;
    chk("ld_ready", {31'd0, u_if.ld_ready}, 32'd1);
    step();
    chk("ld_cnt", {24'd0, u_if.cnt_q}, 32'h5A);
    chk("ld_mode", {28'd0, u_if.slice_mode}, 32'h5);
    chk("ld_busy", {31'd0, u_if.busy}, 32'd1);
    #1;
    chk("ld_ready_in_load", {31'd0, u_if.ld_ready}, 32'd0);
    step();
    chk("ld_mode_after", {28'd0, u_if.slice_mode}, 32'd0);
    #1;
    chk("ld_reaccept", {31'd0, u_if.ld_ready}, 32'd1);
    step();
    u_if.ld_valid = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset in the middle of a run discards it silently.
    do_load(8'h20);
    u_if.run_valid = 1'b1;
    u_if.run_len   = 8'd10;
    step();
    u_if.run_valid = 1'b0;
    step();
    step();
    chk("mid_cnt_before", {24'd0, u_if.cnt_q}, 32'h22);
    rst = 1'b1;
    step();
    chk("mid_rst_cnt", {24'd0, u_if.cnt_q}, 32'd0);
    chk("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("mid_rst_pulse", {31'd0, u_if.done | u_if.aborted}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_quiet", {30'd0, u_if.busy, u_if.done | u_if.aborted}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
